// File: rtl/strip_row_buffer.sv
// rtl/strip_row_buffer.sv - sliding WIN-row strip buffer fed by a raster pixel stream
// A staging row fills pixel by pixel, then commits into the strip.

module strip_row_buffer #(
    parameter int WIN       = 15,
    parameter int DATA_SIZE = 8,
    parameter int IMG_W     = 64
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_SIZE-1:0]            in_pixel,
    input  logic                            in_valid,
    input  logic                            in_sof,
    output logic                            in_ready,
    output logic [DATA_SIZE*IMG_W*WIN-1:0]  strip_out,
    output logic                            strip_valid,
    input  logic                            strip_done,
    output logic [15:0]                     out_row_idx
);

    localparam int ROW_BITS   = DATA_SIZE * IMG_W;
    localparam int STRIP_BITS = ROW_BITS * WIN;
    localparam int CW         = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LW         = $clog2(WIN + 1);

    logic [CW-1:0]         col_q, col_d;
    logic [ROW_BITS-1:0]   staging_q, staging_d;
    logic                  full_q, full_d;
    logic [STRIP_BITS-1:0] rows_q, rows_d;
    logic [LW-1:0]         loaded_q, loaded_d;
    logic                  valid_q, valid_d;
    logic [15:0]           idx_q, idx_d;
    logic [15:0]           frame_row_q, frame_row_d;

    logic          accept;
    logic          commit;
    logic [CW-1:0] wr_col;

    assign accept = in_valid && !full_q;
    // Commit is held off while a strip is being presented; the staging row waits.
    assign commit = full_q && !valid_q;
    assign wr_col = in_sof ? '0 : col_q;

    always_comb begin
        col_d       = col_q;
        staging_d   = staging_q;
        full_d      = full_q;
        rows_d      = rows_q;
        loaded_d    = loaded_q;
        valid_d     = valid_q;
        idx_d       = idx_q;
        frame_row_d = frame_row_q;

        if (commit) begin
            rows_d = rows_q >> ROW_BITS;
            rows_d[STRIP_BITS-1 -: ROW_BITS] = staging_q;
            full_d      = 1'b0;
            loaded_d    = (loaded_q == LW'(WIN)) ? loaded_q : loaded_q + 1'b1;
            idx_d       = frame_row_q;
            frame_row_d = frame_row_q + 16'd1;
            if (loaded_d == LW'(WIN)) begin
                valid_d = 1'b1;
            end
        end

        if (strip_done && valid_q) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            for (int c = 0; c < IMG_W; c++) begin
                if (wr_col == CW'(c)) begin
                    staging_d[c*DATA_SIZE +: DATA_SIZE] = in_pixel;
                end
            end
            if (wr_col == CW'(IMG_W - 1)) begin
                col_d  = '0;
                full_d = 1'b1;
            end else begin
                col_d = wr_col + 1'b1;
            end
            // A new frame discards the strip's validity but keeps its contents.
            if (in_sof) begin
                loaded_d    = '0;
                valid_d     = 1'b0;
                frame_row_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q       <= '0;
            staging_q   <= '0;
            full_q      <= 1'b0;
            rows_q      <= '0;
            loaded_q    <= '0;
            valid_q     <= 1'b0;
            idx_q       <= '0;
            frame_row_q <= '0;
        end else begin
            col_q       <= col_d;
            staging_q   <= staging_d;
            full_q      <= full_d;
            rows_q      <= rows_d;
            loaded_q    <= loaded_d;
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            frame_row_q <= frame_row_d;
        end
    end

    assign in_ready    = !full_q;
    assign strip_out   = rows_q;
    assign strip_valid = valid_q;
    assign out_row_idx = idx_q;

endmodule
